// File: rtl/angular_tap_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : angular_tap_accumulator_pkg
//  Description : Shared intra-prediction constants for the constant-multiplier
//                and tap-accumulator stages: default tap count, product width,
//                output sample width, normalisation shift and clip bounds.
//                Also provides helpers for widths derived from them.
//  Revision    : 1.0  initial release
// ============================================================================
package angular_tap_accumulator_pkg;

    localparam int c_NUM_TAPS = 4;    // tap products per predicted sample
    localparam int c_PROD_W   = 16;   // signed product width
    localparam int c_OUT_W    = 8;    // unsigned predicted-sample width
    localparam int c_SHIFT    = 6;    // coefficient sets sum to 2^c_SHIFT

    localparam int c_CLIP_MIN = 0;
    localparam int c_CLIP_MAX = (1 << c_OUT_W) - 1;

    // Upper clip bound for an arbitrary unsigned sample width.
    function automatic int clip_max(input int out_w);
        return (1 << out_w) - 1;
    endfunction

    // Width of the rounded total: one bit of growth for the pairwise sums,
    // one per level of the pair reduction, and one for the rounding offset.
    function automatic int acc_width(input int prod_w, input int num_taps);
        return prod_w + 1 + $clog2((num_taps + 1) / 2) + 1;
    endfunction

endpackage : angular_tap_accumulator_pkg
`default_nettype wire

// File: rtl/angular_tap_accumulator_sample_round_clip.sv
`default_nettype none
// ============================================================================
//  Module      : sample_round_clip
//  Description : Combinational normalisation of a pre-rounded signed total:
//                arithmetic right shift by SHIFT, then clip to the unsigned
//                range [c_CLIP_MIN, 2^OUT_W-1]. Shared by all filter paths.
//  Ports       : i_value  - signed total with rounding offset already added
//                o_sample - clipped unsigned sample
//  Revision    : 1.0  initial release
// ============================================================================
module sample_round_clip
    import angular_tap_accumulator_pkg::*;
#(
    parameter int IN_W  = 19,
    parameter int SHIFT = c_SHIFT,
    parameter int OUT_W = c_OUT_W
) (
    input  logic signed [IN_W-1:0]  i_value,
    output logic        [OUT_W-1:0] o_sample
);

    localparam logic signed [IN_W-1:0] c_MIN = IN_W'(c_CLIP_MIN);
    localparam logic signed [IN_W-1:0] c_MAX = IN_W'(clip_max(OUT_W));

    logic signed [IN_W-1:0] w_shifted;

    // Arithmetic shift floors towards minus infinity, so together with the
    // +2^(SHIFT-1) offset applied upstream this is round-half-up.
    assign w_shifted = i_value >>> SHIFT;

    always_comb begin
        o_sample = w_shifted[OUT_W-1:0];
        if (w_shifted < c_MIN) begin
            o_sample = OUT_W'(c_CLIP_MIN);
        end else if (w_shifted > c_MAX) begin
            o_sample = OUT_W'(clip_max(OUT_W));
        end
    end

endmodule : sample_round_clip
`default_nettype wire

// File: rtl/angular_tap_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : angular_tap_accumulator
//  Description : Three-stage pipelined accumulator turning NUM_TAPS signed
//                tap products into one clipped predicted sample.
//                  S1: pairwise sums
//                  S2: total + rounding offset 2^(SHIFT-1)
//                  S3: shift, clip, output register
//                All stages advance together on en = out_ready || !out_valid.
//                A row counter flags the last sample of each BLOCK_W row.
//  Ports       : clk, rst     - clock, asynchronous active-high reset
//                in_valid     - tap products valid
//                in_ready     - products accepted this cycle (== en)
//                in_prod      - NUM_TAPS signed products, tap 0 in LSBs
//                out_valid    - predicted sample valid
//                out_ready    - downstream accepts sample
//                out_sample   - clipped predicted sample
//                out_last     - sample is last of a BLOCK_W row
//  Revision    : 1.0  initial release
// ============================================================================
module angular_tap_accumulator
    import angular_tap_accumulator_pkg::*;
#(
    parameter int NUM_TAPS = c_NUM_TAPS,
    parameter int PROD_W   = c_PROD_W,
    parameter int OUT_W    = c_OUT_W,
    parameter int SHIFT    = c_SHIFT,
    parameter int BLOCK_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_TAPS*PROD_W-1:0] in_prod,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_sample,
    output logic                       out_last
);

    localparam int c_NUM_PAIRS = (NUM_TAPS + 1) / 2;
    localparam int c_PAIR_W    = PROD_W + 1;
    localparam int c_TOT_W     = acc_width(PROD_W, NUM_TAPS);
    localparam int c_CNT_W     = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;

    localparam logic        [c_CNT_W-1:0] c_LAST_POS = c_CNT_W'(BLOCK_W - 1);
    localparam logic signed [c_TOT_W-1:0] c_ROUND    = c_TOT_W'(1 << (SHIFT - 1));

    // ------------------------------------------------------------------
    // Pipeline control: a single enable keeps all stages in lock-step, so
    // bubbles travel as invalid stages and nothing can overtake them.
    // ------------------------------------------------------------------
    logic w_en;
    logic r_s1_valid;
    logic r_s2_valid;
    logic r_out_valid;

    assign w_en     = out_ready || !r_out_valid;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // S1: pairwise sums (an odd last tap is paired with zero)
    // ------------------------------------------------------------------
    logic signed [c_PAIR_W-1:0] w_pair_sum [c_NUM_PAIRS];
    logic signed [c_PAIR_W-1:0] r_s1_sum   [c_NUM_PAIRS];

    for (genvar p = 0; p < c_NUM_PAIRS; p++) begin : g_pair
        logic signed [PROD_W-1:0] w_a;
        logic signed [PROD_W-1:0] w_b;

        assign w_a = in_prod[2*p*PROD_W +: PROD_W];

        if (2*p + 1 < NUM_TAPS) begin : g_full
            assign w_b = in_prod[(2*p+1)*PROD_W +: PROD_W];
        end else begin : g_odd
            assign w_b = '0;
        end

        assign w_pair_sum[p] = c_PAIR_W'(w_a) + c_PAIR_W'(w_b);
    end

    // ------------------------------------------------------------------
    // S2: total of the pair sums plus the rounding offset
    // ------------------------------------------------------------------
    logic signed [c_TOT_W-1:0] w_total;
    logic signed [c_TOT_W-1:0] r_s2_total;

    always_comb begin
        w_total = c_ROUND;
        for (int p = 0; p < c_NUM_PAIRS; p++) begin
            w_total = w_total + c_TOT_W'(r_s1_sum[p]);
        end
    end

    // ------------------------------------------------------------------
    // S3: shift and clip
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] w_clipped;
    logic [OUT_W-1:0] r_out_sample;

    sample_round_clip #(
        .IN_W  (c_TOT_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_clip (
        .i_value  (r_s2_total),
        .o_sample (w_clipped)
    );

    // ------------------------------------------------------------------
    // Control registers, output sample and row counter (reset)
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_row_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_row_cnt    <= '0;
        end else begin
            if (w_en) begin
                r_s1_valid  <= in_valid;
                r_s2_valid  <= r_s1_valid;
                r_out_valid <= r_s2_valid;
                // Bubbles leave the last sample value in place.
                if (r_s2_valid) begin
                    r_out_sample <= w_clipped;
                end
            end
            if (r_out_valid && out_ready) begin
                r_row_cnt <= (r_row_cnt == c_LAST_POS) ? '0
                                                       : r_row_cnt + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers (no reset; qualified by the stage valid bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_en) begin
            if (in_valid) begin
                for (int p = 0; p < c_NUM_PAIRS; p++) begin
                    r_s1_sum[p] <= w_pair_sum[p];
                end
            end
            if (r_s1_valid) begin
                r_s2_total <= w_total;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign out_last   = r_out_valid && (r_row_cnt == c_LAST_POS);

endmodule : angular_tap_accumulator
`default_nettype wire

// File: tb/tb_angular_tap_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_angular_tap_accumulator
//  Description : Self-checking bench for angular_tap_accumulator. A negedge
//                scoreboard predicts every emitted sample from the accepted
//                products with plain integer arithmetic and tracks the row
//                position of each output; scenario tasks add their own
//                timing, stall and reset checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_angular_tap_accumulator;

    localparam int NUM_TAPS = 4;
    localparam int PROD_W   = 16;
    localparam int OUT_W    = 8;
    localparam int SHIFT    = 6;
    localparam int BLOCK_W  = 16;
    localparam int c_IN_W   = NUM_TAPS * PROD_W;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [c_IN_W-1:0] in_prod   = '0;
    logic              in_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_sample;
    logic              out_last;

    int checks   = 0;
    int failures = 0;

    int exp_q[$];
    int out_idx   = 0;
    int in_count  = 0;
    int out_count = 0;
    logic [OUT_W-1:0] mon_exp;
    logic             mon_last;

    angular_tap_accumulator #(
        .NUM_TAPS (NUM_TAPS),
        .PROD_W   (PROD_W),
        .OUT_W    (OUT_W),
        .SHIFT    (SHIFT),
        .BLOCK_W  (BLOCK_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_sample(input logic [c_IN_W-1:0] p);
        int total;
        int q;
        total = 0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            total += int'($signed(p[t*PROD_W +: PROD_W]));
        end
        q = (total + (1 << (SHIFT - 1))) >>> SHIFT;   // round half up
        if (q < 0) q = 0;
        if (q > (1 << OUT_W) - 1) q = (1 << OUT_W) - 1;
        return q;
    endfunction

    function automatic logic [c_IN_W-1:0] pack4(input int a, input int b,
                                                 input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [c_IN_W-1:0] rand_prod();
        logic [c_IN_W-1:0] p;
        p = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            if ($urandom_range(0, 1) == 1)
                p[t*PROD_W +: PROD_W] = 16'($urandom_range(0, 65535));
            else
                p[t*PROD_W +: PROD_W] = 16'(int'($urandom_range(0, 12000)) - 3000);
        end
        return p;
    endfunction

    // ---------------- scoreboard ----------------
    // Evaluated mid-cycle: describes the handshakes of the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_output: got sample %0d, required none pending", out_sample);
                end else begin
                    mon_exp  = OUT_W'(exp_q[0]);
                    mon_last = ((out_idx % BLOCK_W) == BLOCK_W - 1);
                    if (out_sample !== mon_exp) begin
                        failures++;
                        $display("FAIL sb_sample #%0d: got %0d, required %0d", out_count, out_sample, mon_exp);
                    end
                    checks++;
                    if (out_last !== mon_last) begin
                        failures++;
                        $display("FAIL sb_last #%0d: got %0b, required %0b", out_count, out_last, mon_last);
                    end
                end
            end else begin
                checks++;
                if (out_last !== 1'b0) begin
                    failures++;
                    $display("FAIL sb_last_idle: got %0b, required 0", out_last);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                out_idx++;
                out_count++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sample(in_prod));
                in_count++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic iv, input logic [c_IN_W-1:0] p, input logic ordy);
        @(posedge clk);
        #2;
        in_valid  = iv;
        in_prod   = p;
        out_ready = ordy;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        out_idx  = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            step(1'b0, '0, 1'b1);
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || out_valid) && n < 30);
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            failures++;
            $display("FAIL drain_timeout: pending %0d out_valid %0b, required 0 and 0", exp_q.size(), out_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
        if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %0b, required 0", out_last); end
        if (out_sample !== '0) begin failures++; $display("FAIL reset_out_sample: got %0d, required 0", out_sample); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int first, lastc, nvalid, nlast, lastpos;
        apply_reset();
        first = -1; lastc = -1; nvalid = 0; nlast = 0; lastpos = -1;
        for (int c = 0; c < 24; c++) begin
            step(c < 17, rand_prod(), 1'b1);
            @(negedge clk);
            if (out_valid) begin
                nvalid++;
                if (first < 0) first = c;
                lastc = c;
            end
            if (out_last) begin
                nlast++;
                lastpos = c;
            end
        end
        checks += 5;
        if (first != 3) begin failures++; $display("FAIL b2b_latency: got first valid cycle %0d, required 3", first); end
        if (lastc != 19) begin failures++; $display("FAIL b2b_last_cycle: got %0d, required 19", lastc); end
        if (nvalid != 17) begin failures++; $display("FAIL b2b_count: got %0d, required 17", nvalid); end
        if (nlast != 1) begin failures++; $display("FAIL b2b_nlast: got %0d, required 1", nlast); end
        if (lastpos != 18) begin failures++; $display("FAIL b2b_lastpos: got cycle %0d, required 18", lastpos); end
    endtask

    task automatic test_directed();
        logic [c_IN_W-1:0] prods [6];
        int                expv  [6];
        logic [OUT_W-1:0]  e;
        prods[0] = pack4(-300, -200, 1200, 400);  expv[0] = 17;
        prods[1] = pack4(0, 0, 16320, 0);         expv[1] = 255;
        prods[2] = pack4(-300, -200, 0, 0);       expv[2] = 0;
        prods[3] = pack4(16000, 16000, 16000, 16000); expv[3] = 255;
        prods[4] = pack4(0, 0, -33, 0);           expv[4] = 0;
        prods[5] = pack4(0, 0, 63, 0);            expv[5] = 1;
        drain();
        for (int i = 0; i < 6; i++) begin
            e = OUT_W'(expv[i]);
            step(1'b1, prods[i], 1'b1);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) step(1'b0, '0, 1'b1);
                @(negedge clk);
                checks++;
                if (k < 3) begin
                    if (out_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL directed_early case %0d cycle %0d: got out_valid %0b, required 0", i, k, out_valid);
                    end
                end else if (out_valid !== 1'b1 || out_sample !== e) begin
                    failures++;
                    $display("FAIL directed_value case %0d: got valid %0b sample %0d, required 1 and %0d", i, out_valid, out_sample, e);
                end
            end
        end
        drain();
    endtask

    task automatic test_stall();
        logic [OUT_W-1:0] held;
        logic             ordy;
        held = '0;
        for (int c = 0; c < 24; c++) begin
            ordy = !(c >= 8 && c < 13);
            step(c < 20, rand_prod(), ordy);
            #1;
            if (!ordy) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready cycle %0d: got valid %0b in_ready %0b, required 1 and 0", c, out_valid, in_ready);
                end
            end
            @(negedge clk);
            if (c == 8) begin
                held = out_sample;
            end else if (c > 8 && c < 13) begin
                checks++;
                if (out_sample !== held) begin
                    failures++;
                    $display("FAIL stall_hold cycle %0d: got %0d, required %0d", c, out_sample, held);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        int nlast, lastpos;
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, rand_prod(), 1'b0);
        step(1'b0, '0, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL inflight_pre: got out_valid %0b, required 1", out_valid); end
        rst = 1'b1;
        exp_q.delete();
        out_idx = 0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL inflight_valid: got %0b, required 0", out_valid); end
        if (out_last !== 1'b0) begin failures++; $display("FAIL inflight_last: got %0b, required 0", out_last); end
        if (out_sample !== '0) begin failures++; $display("FAIL inflight_sample: got %0d, required 0", out_sample); end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, '0, 1'b1);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL inflight_stale cycle %0d: got out_valid 1, required 0", c); end
        end
        nlast = 0; lastpos = -1;
        for (int c = 0; c < 24; c++) begin
            step(c < 17, rand_prod(), 1'b1);
            @(negedge clk);
            if (out_last) begin nlast++; lastpos = c; end
        end
        checks += 2;
        if (nlast != 1) begin failures++; $display("FAIL inflight_nlast: got %0d, required 1", nlast); end
        if (lastpos != 18) begin failures++; $display("FAIL inflight_lastpos: got cycle %0d, required 18", lastpos); end
    endtask

    task automatic test_random();
        int base_in, base_out, cyc;
        base_in  = in_count;
        base_out = out_count;
        cyc = 0;
        while ((in_count - base_in) < 1000 && cyc < 8000) begin
            step($urandom_range(0, 9) < 7, rand_prod(), $urandom_range(0, 9) < 7);
            cyc++;
        end
        drain();
        checks += 2;
        if ((in_count - base_in) < 1000) begin
            failures++;
            $display("FAIL random_timeout: got %0d inputs, required 1000", in_count - base_in);
        end
        if ((out_count - base_out) != (in_count - base_in)) begin
            failures++;
            $display("FAIL random_count: got %0d outputs, required %0d", out_count - base_out, in_count - base_in);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_directed();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_angular_tap_accumulator
`default_nettype wire
